// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: host/line bundle for the UART receive framer.
// master = line + host side, slave = framer.
interface uart_rx_frame_if #(
  parameter int K_W = 19
);
  logic           rx;
  logic [K_W-1:0] baud_k;
  logic           eight;
  logic           pen;
  logic           ohel;
  logic           rd_ack;
  logic [7:0]     rx_data;
  logic           rx_rdy;
  logic           perr;
  logic           ferr;
  logic           ovf;

  modport master (
    output rx,
    output baud_k,
    output eight,
    output pen,
    output ohel,
    output rd_ack,
    input  rx_data,
    input  rx_rdy,
    input  perr,
    input  ferr,
    input  ovf
  );

  modport slave (
    input  rx,
    input  baud_k,
    input  eight,
    input  pen,
    input  ohel,
    input  rd_ack,
    output rx_data,
    output rx_rdy,
    output perr,
    output ferr,
    output ovf
  );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive framer, 7/8 data bits, optional parity.
// Build option RX_MAJORITY_EN: 3-sample majority vote per bit sample.
module uart_rx_frame #(
  parameter int K_W    = 19,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_frame_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT,
    DONE
  } state_t;

  state_t r_state;

  logic r_meta;
  logic r_rxs;

  logic [K_W-1:0] r_timer;
  logic [K_W-1:0] r_k;
  logic           r_eight;
  logic           r_pen;
  logic           r_ohel;

  logic              r_armed;
  logic [3:0]        r_bcnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;

  logic [7:0] r_data;
  logic       r_rdy;
  logic       r_perr;
  logic       r_ferr;
  logic       r_ovf;

  logic       w_rxs;
  logic       w_samp;
  logic       w_btu;
  logic [3:0] w_ndata;
  logic [3:0] w_last;
  logic       w_is_data;
  logic       w_is_stop;
  logic [7:0] w_data;
  logic       w_perr;

  assign w_rxs = r_rxs;

  // two-flop synchronizer, idles high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_rxs  <= 1'b1;
    end else begin
      r_meta <= bus.rx;
      r_rxs  <= r_meta;
    end
  end

`ifdef RX_MAJORITY_EN
  logic r_h1;
  logic r_h2;

  // last two synchronized samples for the vote
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h1 <= 1'b1;
      r_h2 <= 1'b1;
    end else begin
      r_h1 <= w_rxs;
      r_h2 <= r_h1;
    end
  end

  assign w_samp = (w_rxs & r_h1)
                | (w_rxs & r_h2)
                | (r_h1  & r_h2);
`else
  assign w_samp = w_rxs;
`endif

  assign w_btu = (r_timer == K_W'(1));

  assign w_ndata = r_eight ? 4'd8 : 4'd7;
  assign w_last  = w_ndata
                 + {3'd0, r_pen}
                 + 4'd1;

  assign w_is_data = (r_bcnt <= w_ndata);
  assign w_is_stop = (r_bcnt == w_last);

  // 7-bit frames land in [7:1]; right-justify
  assign w_data = r_eight
                ? r_shift[7:0]
                : {1'b0, r_shift[7:1]};

  assign w_perr = r_pen
                & (r_par != ((^w_data) ^ r_ohel));

  // frame FSM with bit timer, bit counter and host flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_k     <= '0;
      r_eight <= 1'b0;
      r_pen   <= 1'b0;
      r_ohel  <= 1'b0;
      r_armed <= 1'b1;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (bus.rd_ack) begin
        r_rdy <= 1'b0;
        r_ovf <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          r_bcnt  <= '0;
          r_timer <= '0;
          if (w_rxs) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_armed <= 1'b0;
            r_k     <= bus.baud_k;
            r_eight <= bus.eight;
            r_pen   <= bus.pen;
            r_ohel  <= bus.ohel;
            r_timer <= bus.baud_k >> 1;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_btu) begin
            if (w_samp) begin
              r_armed <= 1'b1;
              r_timer <= '0;
              r_state <= IDLE;
            end else begin
              r_timer <= r_k;
              r_bcnt  <= 4'd1;
              r_state <= SHIFT;
            end
          end else begin
            r_timer <= r_timer - K_W'(1);
          end
        end
        SHIFT: begin
          if (w_btu) begin
            r_timer <= r_k;
            r_bcnt  <= r_bcnt + 4'd1;
            if (w_is_stop) begin
              r_data  <= w_data;
              r_perr  <= w_perr;
              r_ferr  <= ~w_samp;
              r_rdy   <= 1'b1;
              r_ovf   <= r_rdy & ~bus.rd_ack;
              r_state <= DONE;
            end else if (w_is_data) begin
              r_shift <= {w_samp,
                          r_shift[DATA_W-1:1]};
            end else begin
              r_par <= w_samp;
            end
          end else begin
            r_timer <= r_timer - K_W'(1);
          end
        end
        DONE: begin
          // a line still low here (break) must rise before rearming
          r_armed <= w_rxs;
          r_bcnt  <= '0;
          r_timer <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rx_data = r_data;
  assign bus.rx_rdy  = r_rdy;
  assign bus.perr    = r_perr;
  assign bus.ferr    = r_ferr;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: scoreboard bench for the UART receive framer.
// Stimulus pushes expected frames; a monitor pops on each new byte.
module tb_uart_rx_frame;
  localparam int K_W = 19;
`ifdef RX_MAJORITY_EN
  localparam int KMIN = 8;
`else
  localparam int KMIN = 4;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  uart_rx_frame_if #(.K_W(K_W)) bus();

  uart_rx_frame #(
    .K_W(K_W),
    .DATA_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    bit          perr;
    bit          ferr;
    bit          ovf;
    int unsigned at;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   hold_ack = 1'b0;
  bit   ack_on = 1'b0;
  bit   pr = 1'b0;
  bit   po = 1'b0;
  exp_t me;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h need %h", nm, act, req);
    end
  endtask

  // reference: frame rules straight from the line format
  function automatic exp_t model(input logic [7:0] d,
                                 input bit e8, pn, oh,
                                 input bit pb, st,
                                 input int k,
                                 input int unsigned c0,
                                 input bit ov);
    exp_t r;
    int   nb;
    bit   want;
    r.data = e8 ? d : {1'b0, d[6:0]};
    want   = (($countones(r.data) % 2) == 1) ^ oh;
    r.perr = pn && (pb != want);
    r.ferr = !st;
    r.ovf  = ov;
    nb     = 1 + (e8 ? 8 : 7) + (pn ? 1 : 0) + 1;
    // 2 sync stages, then N0 + half + (nbits-1)*k + 1
    r.at   = c0 + 2 + k / 2 + (nb - 1) * k + 1;
    return r;
  endfunction

  // drive one frame cycle by cycle; entered/left #1 after posedge
  task automatic send(input logic [7:0] d,
                      input bit e8, pn, oh, pb, st,
                      input int k, input int cut,
                      input bit glitch);
    logic [10:0] bits;
    int nd;
    int nb;
    int bi;
    nd = e8 ? 8 : 7;
    nb = nd + (pn ? 1 : 0) + 2;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) bits[1 + i] = d[i];
    if (pn) bits[1 + nd] = pb;
    bits[nb - 1] = st;
    bus.baud_k = K_W'(k);
    bus.eight  = e8;
    bus.pen    = pn;
    bus.ohel   = oh;
    for (int t = 0; t < nb * k; t++) begin
      if (cut > 0 && t == cut) break;
      bi = t / k;
      bus.rx = bits[bi] ^ (glitch && bi >= 1 && bi <= nd
                           && (t % k) == k / 2);
      if (t == k) begin
        bus.baud_k = K_W'($urandom_range(40, 4));
        bus.eight  = 1'($urandom);
        bus.pen    = 1'($urandom);
        bus.ohel   = 1'($urandom);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send_chk(input logic [7:0] d,
                          input bit e8, pn, oh, pb, st,
                          input int k, input bit glitch,
                          input bit ov);
    q.push_back(model(d, e8, pn, oh, pb, st, k, cyc, ov));
    send(d, e8, pn, oh, pb, st, k, 0, glitch);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ack();
    bus.rd_ack = 1'b1;
    @(posedge clk); #1;
    bus.rd_ack = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (q.size() > 0 && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d frames pending, need 0", q.size());
      q.delete();
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.rx_data, bus.rx_rdy,
                bus.perr, bus.ferr, bus.ovf});
  endfunction

  // monitor: a new byte is a rising rx_rdy or a rising ovf
  initial begin
    forever begin
      @(negedge clk);
      if (ack_on) begin
        bus.rd_ack = 1'b0;
        ack_on = 1'b0;
      end
      if (reset && ((bus.rx_rdy && !pr) || (bus.ovf && !po))) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: data=%h ovf=%b, need none",
                   bus.rx_data, bus.ovf);
        end else begin
          me = q.pop_front();
          chk("frame", 32'({bus.rx_data, bus.perr, bus.ferr, bus.ovf}),
              32'({me.data, me.perr, me.ferr, me.ovf}));
          chk("latency", cyc, me.at);
        end
        if (!hold_ack) begin
          bus.rd_ack = 1'b1;
          ack_on = 1'b1;
        end
      end
      pr = bus.rx_rdy;
      po = bus.ovf;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int upd;
    bit e8, pn, oh, pb, st;
    logic [7:0] d;

    bus.rx = 1'b1;
    bus.rd_ack = 1'b0;
    bus.baud_k = K_W'(16);
    bus.eight = 1'b1;
    bus.pen = 1'b0;
    bus.ohel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 32'd0);
    reset = 1'b1;
    idle(3);

    send_chk(8'hA5, 1, 0, 0, 0, 1, 16, 0, 0);
    drain(1000);

    send_chk(8'h35, 0, 1, 1, 1, 1, 16, 0, 0);
    send_chk(8'h35, 0, 1, 1, 0, 1, 16, 0, 0);
    send_chk(8'hB5, 0, 0, 0, 0, 1, 16, 0, 0);
    drain(1000);

    send_chk(8'h3C, 1, 0, 0, 0, 0, 16, 0, 0);
    idle(4);
    send_chk(8'h3C, 1, 0, 0, 0, 1, 16, 0, 0);
    drain(1000);

    hold_ack = 1'b1;
    send_chk(8'h11, 1, 0, 0, 0, 1, 16, 0, 0);
    send_chk(8'h22, 1, 0, 0, 0, 1, 16, 0, 1);
    drain(1000);
    ack();
    chk("ovf_cleared", outs(), 32'({8'h22, 4'b0000}));

    send_chk(8'h11, 1, 0, 0, 0, 1, 16, 0, 0);
    drain(1000);
    upd = 2 + 8 + 9 * 16 + 1;
    fork
      send(8'h22, 1, 0, 0, 0, 1, 16, 0, 0);
      begin
        repeat (upd - 1) @(posedge clk);
        #2 bus.rd_ack = 1'b1;
        @(posedge clk);
        #2 bus.rd_ack = 1'b0;
      end
    join
    chk("ack_on_done", outs(), 32'({8'h22, 4'b1000}));
    ack();
    hold_ack = 1'b0;

    bus.rx = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    idle(40);
    chk("false_start", 32'(bus.rx_rdy), 32'd0);

    hold_ack = 1'b1;
    send_chk(8'h77, 1, 1, 1, 1, 1, 16, 0, 0);
    drain(1000);
    send(8'h00, 1, 0, 0, 0, 1, 16, 4 * 16 + 8, 0);
    reset = 1'b0;
    #1;
    chk("reset_mid", outs(), 32'd0);
    idle(3);
    reset = 1'b1;
    hold_ack = 1'b0;
    idle(3);
    send_chk(8'h5A, 1, 0, 0, 0, 1, 16, 0, 0);
    drain(1000);

    send_chk(8'h00, 1, 0, 0, 0, 0, 16, 0, 0);
    bus.rx = 1'b0;
    repeat (80) begin @(posedge clk); #1; end
    idle(5);
    send_chk(8'hC3, 1, 0, 0, 0, 1, 16, 0, 0);
    drain(1000);

    send_chk(8'h96, 1, 1, 0, 0, 1, KMIN, 0, 0);
    send_chk(8'h4B, 0, 1, 0, 0, 1, KMIN + 1, 0, 0);
    drain(1000);

`ifdef RX_MAJORITY_EN
    send_chk(8'hF0, 1, 0, 0, 0, 1, 16, 1, 0);
    drain(1000);
`endif

    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(24, KMIN);
      e8 = 1'($urandom);
      pn = 1'($urandom);
      oh = 1'($urandom);
      pb = 1'($urandom);
      st = ($urandom_range(5, 0) != 0);
      d  = 8'($urandom);
      send_chk(d, e8, pn, oh, pb, st, k, 0, 0);
      if (!st) idle(3 + $urandom_range(k, 0));
      else idle($urandom_range(2, 0));
    end
    drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
